disp_sink: RTL and testbench

- Display-stream receiver: the consuming end of the pixel interface that chapter tops drive (sync, data enable, RGB at BPC bits per channel).
- Recovers pixel coordinates and frame start from the sync and DE signals alone.
- Measures active geometry, tracks lock against that geometry, and optionally signs each frame with a CRC.
- Used by simulation benches and on-board loopback to check display output without a monitor.

---
 rtl/disp_sink_if.sv | 23 ++
 rtl/disp_sink.sv | 245 ++++++++++++++++++++++++
 tb/tb_disp_sink.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/disp_sink_if.sv
// Display pixel stream bundle (sync, data enable, RGB) shared by the
// driving top and the disp_sink receiver.
interface disp_sink_if #(
    parameter int BPC = 5
);
    // Stream semantics: there is no backpressure. The source presents one
    // pixel slot per clk_pix cycle; disp_de high marks an active pixel whose
    // colour on disp_r/g/b is valid in that same cycle, and the sink always
    // accepts it (an implicit ready that is permanently high).
    logic           disp_vsync;
    logic           disp_de;
    logic [BPC-1:0] disp_r;
    logic [BPC-1:0] disp_g;
    logic [BPC-1:0] disp_b;

    modport master (
        output disp_vsync, disp_de, disp_r, disp_g, disp_b
    );

    modport slave (
        input disp_vsync, disp_de, disp_r, disp_g, disp_b
    );
endinterface

// File: rtl/disp_sink.sv
// Display-stream receiver: recovers x/y/frame from vsync and DE, measures
// active geometry, tracks lock and counts geometry errors.
// Optional frame CRC-16-CCITT signature enabled by defining DISP_SINK_CRC_EN.
// Pipeline: stage 1 registers the pins, stage 2 holds counters and events,
// stage 3 drives cap_* together with the lock state machine outputs.
module disp_sink #(
    parameter int   BPC    = 5,
    parameter int   CORDW  = 16,
    parameter logic VS_POL = 1'b1
) (
    input  logic             clk_pix,
    input  logic             rst_pix_n,
    disp_sink_if.slave       disp,
    output logic [CORDW-1:0] cap_x,
    output logic [CORDW-1:0] cap_y,
    output logic             cap_de,
    output logic             cap_frame,
    output logic [BPC-1:0]   cap_r,
    output logic [BPC-1:0]   cap_g,
    output logic [BPC-1:0]   cap_b,
    output logic [CORDW-1:0] meas_width,
    output logic [CORDW-1:0] meas_height,
    output logic             locked,
    output logic             lock_err,
    output logic [7:0]       err_cnt,
    output logic [15:0]      frame_crc,
    output logic             crc_valid,
    output logic [1:0]       fsm_state
);
    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    function automatic logic [CORDW-1:0] sat_inc(input logic [CORDW-1:0] v);
        return (v == {CORDW{1'b1}}) ? v : v + 1'b1;
    endfunction

    // Stage 1 registers
    logic           s1_act, s1_act_d, s1_de, s1_de_d;
    logic [BPC-1:0] s1_r, s1_g, s1_b;
    logic           frame_ev, line_end;

    // Stage 2 registers
    logic             s2_de, s2_frame, s2_line_end;
    logic [BPC-1:0]   s2_r, s2_g, s2_b;
    logic [CORDW-1:0] x_cnt, y_cnt, s2_width, s2_height;
    logic [CORDW-1:0] y_after_line;

    // State machine registers
    state_t           state;
    logic [CORDW-1:0] ref_w;
    logic             have_ref, mismatch;
    logic             mm_now, lk_line_err, lk_frame_err;
    logic [CORDW-1:0] ref_now;

    // Register the pins; sync activity is normalised to active-high here.
    always_ff @(posedge clk_pix or negedge rst_pix_n) begin
        if (!rst_pix_n) begin
            s1_act   <= 1'b0;
            s1_act_d <= 1'b0;
            s1_de    <= 1'b0;
            s1_de_d  <= 1'b0;
            s1_r     <= '0;
            s1_g     <= '0;
            s1_b     <= '0;
        end else begin
            s1_act   <= (disp.disp_vsync == VS_POL);
            s1_act_d <= s1_act;
            s1_de    <= disp.disp_de;
            s1_de_d  <= s1_de;
            s1_r     <= disp.disp_r;
            s1_g     <= disp.disp_g;
            s1_b     <= disp.disp_b;
        end
    end

    assign frame_ev     = s1_act & ~s1_act_d;
    assign line_end     = s1_de_d & ~s1_de;
    // A line ending in the frame-event cycle still belongs to the old frame.
    assign y_after_line = line_end ? sat_inc(y_cnt) : y_cnt;

    // Coordinate counters plus the line/frame events that feed the FSM.
    always_ff @(posedge clk_pix or negedge rst_pix_n) begin
        if (!rst_pix_n) begin
            s2_de       <= 1'b0;
            s2_frame    <= 1'b0;
            s2_line_end <= 1'b0;
            s2_r        <= '0;
            s2_g        <= '0;
            s2_b        <= '0;
            x_cnt       <= '0;
            y_cnt       <= '0;
            s2_width    <= '0;
            s2_height   <= '0;
        end else begin
            s2_de       <= s1_de;
            s2_frame    <= frame_ev;
            s2_line_end <= line_end;
            s2_r        <= s1_r;
            s2_g        <= s1_g;
            s2_b        <= s1_b;
            if (s1_de)
                x_cnt <= s1_de_d ? sat_inc(x_cnt) : '0;
            if (line_end)
                s2_width <= sat_inc(x_cnt);
            if (frame_ev) begin
                s2_height <= y_after_line;
                y_cnt     <= '0;
            end else begin
                y_cnt <= y_after_line;
            end
        end
    end

    // Capture outputs, two cycles behind the pins.
    always_ff @(posedge clk_pix or negedge rst_pix_n) begin
        if (!rst_pix_n) begin
            cap_x     <= '0;
            cap_y     <= '0;
            cap_de    <= 1'b0;
            cap_frame <= 1'b0;
            cap_r     <= '0;
            cap_g     <= '0;
            cap_b     <= '0;
        end else begin
            cap_x     <= x_cnt;
            cap_y     <= y_cnt;
            cap_de    <= s2_de;
            cap_frame <= s2_frame;
            cap_r     <= s2_r;
            cap_g     <= s2_g;
            cap_b     <= s2_b;
        end
    end

    // A line end coinciding with a frame event is folded in before the
    // frame decision, so its width and its count land in the closing frame.
    assign mm_now       = mismatch | (s2_line_end & have_ref & (s2_width != ref_w));
    assign ref_now      = have_ref ? ref_w : s2_width;
    assign lk_line_err  = s2_line_end & (s2_width != meas_width);
    assign lk_frame_err = s2_frame & (s2_height != meas_height);

    // Lock tracking: SEARCH -> MEASURE -> LOCKED, dropping out on mismatch.
    always_ff @(posedge clk_pix or negedge rst_pix_n) begin
        if (!rst_pix_n) begin
            state       <= SEARCH;
            ref_w       <= '0;
            have_ref    <= 1'b0;
            mismatch    <= 1'b0;
            meas_width  <= '0;
            meas_height <= '0;
            locked      <= 1'b0;
            lock_err    <= 1'b0;
            err_cnt     <= '0;
        end else begin
            lock_err <= 1'b0;
            case (state)
                SEARCH: begin
                    if (s2_frame) begin
                        state    <= MEASURE;
                        have_ref <= 1'b0;
                        mismatch <= 1'b0;
                    end
                end
                MEASURE: begin
                    if (s2_frame) begin
                        if ((s2_height != '0) && !mm_now) begin
                            meas_width  <= ref_now;
                            meas_height <= s2_height;
                            locked      <= 1'b1;
                            state       <= LOCKED;
                        end
                        have_ref <= 1'b0;
                        mismatch <= 1'b0;
                    end else if (s2_line_end) begin
                        if (!have_ref) begin
                            ref_w    <= s2_width;
                            have_ref <= 1'b1;
                        end else if (s2_width != ref_w) begin
                            mismatch <= 1'b1;
                        end
                    end
                end
                LOCKED: begin
                    if (lk_line_err || lk_frame_err) begin
                        lock_err <= 1'b1;
                        err_cnt  <= (err_cnt == 8'hFF) ? err_cnt : err_cnt + 8'd1;
                        locked   <= 1'b0;
                        have_ref <= 1'b0;
                        mismatch <= 1'b0;
                        // A frame event in the same cycle starts a new measurement.
                        state    <= s2_frame ? MEASURE : SEARCH;
                    end
                end
                default: state <= SEARCH;
            endcase
        end
    end

    assign fsm_state = state;

`ifdef DISP_SINK_CRC_EN
    logic [15:0] crc_run, crc_snap;

    // CRC-16-CCITT over one {r,g,b} word per clock, MSB first.
    function automatic logic [15:0] crc_step(input logic [15:0] c,
                                             input logic [3*BPC-1:0] w);
        logic [15:0] r;
        r = c;
        for (int i = 3*BPC-1; i >= 0; i--)
            r = {r[14:0], 1'b0} ^ (((r[15] ^ w[i]) == 1'b1) ? 16'h1021 : 16'h0000);
        return r;
    endfunction

    // Running CRC in stage 2; snapshot and reload at each frame event.
    always_ff @(posedge clk_pix or negedge rst_pix_n) begin
        if (!rst_pix_n) begin
            crc_run  <= 16'hFFFF;
            crc_snap <= '0;
        end else if (frame_ev) begin
            crc_snap <= crc_run;
            crc_run  <= s1_de ? crc_step(16'hFFFF, {s1_r, s1_g, s1_b}) : 16'hFFFF;
        end else if (s1_de) begin
            crc_run <= crc_step(crc_run, {s1_r, s1_g, s1_b});
        end
    end

    // Publish the signature in step with cap_frame.
    always_ff @(posedge clk_pix or negedge rst_pix_n) begin
        if (!rst_pix_n) begin
            frame_crc <= '0;
            crc_valid <= 1'b0;
        end else begin
            crc_valid <= s2_frame;
            if (s2_frame)
                frame_crc <= crc_snap;
        end
    end
`else
    assign frame_crc = '0;
    assign crc_valid = 1'b0;
`endif
endmodule

// File: tb/tb_disp_sink.sv
// Directed bench for disp_sink: two instances (active-high and active-low
// vsync) fed the same stream; cap_* tracked against a two-deep expected pipe.
module tb_disp_sink;
    localparam int BPC   = 5;
    localparam int CORDW = 16;
    localparam logic [1:0] ST_SEARCH  = 2'd0;
    localparam logic [1:0] ST_MEASURE = 2'd1;
    localparam logic [1:0] ST_LOCKED  = 2'd2;

    // Clock and reset
    logic clk_pix = 1'b0;
    logic rst_pix_n;
    always #5 clk_pix = ~clk_pix;

    disp_sink_if #(.BPC(BPC)) if_a ();
    disp_sink_if #(.BPC(BPC)) if_b ();

    logic [CORDW-1:0] a_cap_x, a_cap_y, a_meas_width, a_meas_height;
    logic             a_cap_de, a_cap_frame, a_locked, a_lock_err, a_crc_valid;
    logic [BPC-1:0]   a_cap_r, a_cap_g, a_cap_b;
    logic [7:0]       a_err_cnt;
    logic [15:0]      a_frame_crc;
    logic [1:0]       a_fsm_state;

    logic [CORDW-1:0] b_cap_x, b_cap_y, b_meas_width, b_meas_height;
    logic             b_cap_de, b_cap_frame, b_locked, b_lock_err, b_crc_valid;
    logic [BPC-1:0]   b_cap_r, b_cap_g, b_cap_b;
    logic [7:0]       b_err_cnt;
    logic [15:0]      b_frame_crc;
    logic [1:0]       b_fsm_state;

    disp_sink #(.BPC(BPC), .CORDW(CORDW), .VS_POL(1'b1)) dut_a (
        .clk_pix(clk_pix), .rst_pix_n(rst_pix_n), .disp(if_a.slave),
        .cap_x(a_cap_x), .cap_y(a_cap_y), .cap_de(a_cap_de), .cap_frame(a_cap_frame),
        .cap_r(a_cap_r), .cap_g(a_cap_g), .cap_b(a_cap_b),
        .meas_width(a_meas_width), .meas_height(a_meas_height),
        .locked(a_locked), .lock_err(a_lock_err), .err_cnt(a_err_cnt),
        .frame_crc(a_frame_crc), .crc_valid(a_crc_valid), .fsm_state(a_fsm_state)
    );

    disp_sink #(.BPC(BPC), .CORDW(CORDW), .VS_POL(1'b0)) dut_b (
        .clk_pix(clk_pix), .rst_pix_n(rst_pix_n), .disp(if_b.slave),
        .cap_x(b_cap_x), .cap_y(b_cap_y), .cap_de(b_cap_de), .cap_frame(b_cap_frame),
        .cap_r(b_cap_r), .cap_g(b_cap_g), .cap_b(b_cap_b),
        .meas_width(b_meas_width), .meas_height(b_meas_height),
        .locked(b_locked), .lock_err(b_lock_err), .err_cnt(b_err_cnt),
        .frame_crc(b_frame_crc), .crc_valid(b_crc_valid), .fsm_state(b_fsm_state)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Expected pipe: index 0 = driven last call, index 1 = two calls ago.
    logic           p_de[2], p_fr[2];
    int             p_x[2], p_y[2];
    logic [BPC-1:0] p_r[2], p_g[2], p_b[2];
    logic           prev_act;
    logic [15:0]    crc_run_m, crc_snap_m;

    // Bit-serial CRC-16-CCITT reference.
    function automatic logic [15:0] crc_model(input logic [15:0] c, input logic [3*BPC-1:0] w);
        logic [15:0] r;
        logic        fb;
        r = c;
        for (int i = 3*BPC-1; i >= 0; i--) begin
            fb = r[15] ^ w[i];
            r  = r << 1;
            if (fb) r = r ^ 16'h1021;
        end
        return r;
    endfunction

    // Scoreboard comparison
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 2; i++) begin
            p_de[i] = 1'b0; p_fr[i] = 1'b0; p_x[i] = 0; p_y[i] = 0;
            p_r[i] = '0; p_g[i] = '0; p_b[i] = '0;
        end
        prev_act   = 1'b0;
        crc_run_m  = 16'hFFFF;
        crc_snap_m = 16'h0000;
    endtask

    task automatic drive(input logic vs, input logic de, input logic [BPC-1:0] r, g, b);
        if_a.disp_vsync = vs;  if_b.disp_vsync = ~vs;
        if_a.disp_de = de;     if_b.disp_de = de;
        if_a.disp_r = r; if_a.disp_g = g; if_a.disp_b = b;
        if_b.disp_r = r; if_b.disp_g = g; if_b.disp_b = b;
    endtask

    // One pixel slot: drive, advance a clock, compare cap_* with two slots ago.
    task automatic cycle(input logic vs, input logic de, input int x, input int y,
                         input logic [BPC-1:0] r, g, b);
        logic fr;
        drive(vs, de, r, g, b);
        fr = vs & ~prev_act;
        prev_act = vs;
        if (fr) begin
            crc_snap_m = crc_run_m;
            crc_run_m  = 16'hFFFF;
        end
        if (de) crc_run_m = crc_model(crc_run_m, {r, g, b});
        @(posedge clk_pix); #1;
        check("cap_de", a_cap_de, p_de[1]);
        check("cap_frame", a_cap_frame, p_fr[1]);
        check("b_cap_frame", b_cap_frame, p_fr[1]);
        if (p_de[1]) begin
            check("cap_x", a_cap_x, p_x[1]);
            check("cap_y", a_cap_y, p_y[1]);
            check("cap_rgb", {a_cap_r, a_cap_g, a_cap_b}, {p_r[1], p_g[1], p_b[1]});
        end
        p_de[1] = p_de[0]; p_fr[1] = p_fr[0]; p_x[1] = p_x[0]; p_y[1] = p_y[0];
        p_r[1] = p_r[0]; p_g[1] = p_g[0]; p_b[1] = p_b[0];
        p_de[0] = de; p_fr[0] = fr; p_x[0] = x; p_y[0] = y;
        p_r[0] = r; p_g[0] = g; p_b[0] = b;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_cap"}, {a_cap_x, a_cap_y, a_cap_de, a_cap_frame}, 32'h0);
        check({tag, "_rgb"}, {a_cap_r, a_cap_g, a_cap_b}, 32'h0);
        check({tag, "_meas"}, {a_meas_width, a_meas_height}, 32'h0);
        check({tag, "_lock"}, {a_locked, a_lock_err, a_err_cnt, a_fsm_state}, 32'h0);
        check({tag, "_crc"}, {a_frame_crc, a_crc_valid}, 32'h0);
        check({tag, "_b_all"}, {b_cap_de, b_cap_frame, b_locked, b_lock_err, b_err_cnt,
                                b_crc_valid, b_fsm_state}, 32'h0);
        check({tag, "_b_meas"}, {b_meas_width, b_meas_height}, 32'h0);
    endtask

    // Reset with no clock edge needed for the outputs to clear.
    task automatic do_reset();
        rst_pix_n = 1'b0;
        drive(1'b0, 1'b0, '0, '0, '0);
        #1;
        check_all_zero("reset");
        clear_model();
        repeat (3) @(posedge clk_pix);
        #1;
        rst_pix_n = 1'b1;
    endtask

    task automatic check_lock(input string tag, input logic lk, input logic er,
                              input logic [7:0] errs, input logic [1:0] st);
        check({tag, "_locked"}, a_locked, lk);
        check({tag, "_b_locked"}, b_locked, lk);
        check({tag, "_lock_err"}, a_lock_err, er);
        check({tag, "_b_lock_err"}, b_lock_err, er);
        check({tag, "_err_cnt"}, a_err_cnt, errs);
        check({tag, "_b_err_cnt"}, b_err_cnt, errs);
        check({tag, "_state"}, a_fsm_state, st);
        check({tag, "_b_state"}, b_fsm_state, st);
    endtask

    // One frame: 2 vsync cycles, 2 blank, then nlines lines of 8 DE + 4 hblank.
    task automatic frame(input int nlines, input int short_idx, input bit solid,
                         input bit lock_before, input bit lock_after, input bit err_vs,
                         input logic [7:0] errs_vs, input logic [1:0] st_vs);
        logic [15:0] snap_exp;
        int          w;
        snap_exp = 16'h0;
        for (int i = 0; i < 4; i++) begin
            cycle(i < 2, 1'b0, 0, 0, '0, '0, '0);
            if (i == 0) snap_exp = crc_snap_m;
            if (i == 1) begin
                check("vs_pre_locked", a_locked, lock_before);
                check("vs_pre_lock_err", a_lock_err, 1'b0);
                check("vs_pre_crc_valid", a_crc_valid, 1'b0);
            end
            if (i == 2) begin
                check_lock("vs", lock_after, err_vs, errs_vs, st_vs);
                if (lock_after) begin
                    check("meas_width", a_meas_width, 8);
                    check("meas_height", a_meas_height, 4);
                    check("b_meas", {b_meas_width, b_meas_height}, {16'd8, 16'd4});
                end
`ifdef DISP_SINK_CRC_EN
                check("crc_valid", a_crc_valid, 1'b1);
                check("frame_crc", a_frame_crc, snap_exp);
                check("b_frame_crc", b_frame_crc, snap_exp);
`else
                check("crc_valid_off", a_crc_valid, 1'b0);
                check("frame_crc_off", a_frame_crc, 16'h0);
`endif
            end
            if (i == 3) check("vs_post_lock_err", a_lock_err, 1'b0);
        end
        for (int l = 0; l < nlines; l++) begin
            w = (l == short_idx) ? 7 : 8;
            for (int p = 0; p < w; p++)
                cycle(1'b0, 1'b1, p, l,
                      solid ? 5'h1F : BPC'(p), solid ? 5'h1F : BPC'(l),
                      solid ? 5'h1F : BPC'(p + l + 3));
            for (int j = 0; j < 4; j++) begin
                cycle(1'b0, 1'b0, 0, 0, '0, '0, '0);
                if (l == short_idx) begin
                    if (j == 1) check("short_pre_err", a_lock_err, 1'b0);
                    if (j == 2) check_lock("short", 1'b0, 1'b1, errs_vs + 8'd1, ST_SEARCH);
                    if (j == 3) check("short_post_err", a_lock_err, 1'b0);
                end
            end
        end
    endtask

    // Stimulus
    initial begin
        rst_pix_n = 1'b1;
        clear_model();
        drive(1'b0, 1'b0, '0, '0, '0);
        #2;
        do_reset();

        //    lines sh solid pre post err errs st
        frame(4, -1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, ST_MEASURE);  // first vsync
        frame(4, -1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, ST_LOCKED);   // lock 8x4
        frame(4, -1, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0, ST_LOCKED);
        frame(4,  1, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0, ST_LOCKED);   // short line
        frame(4, -1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1, ST_MEASURE);
        frame(4, -1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1, ST_LOCKED);   // relocked
        frame(5, -1, 1'b0, 1'b1, 1'b1, 1'b0, 8'd1, ST_LOCKED);   // extra line
        frame(4, -1, 1'b0, 1'b1, 1'b0, 1'b1, 8'd2, ST_MEASURE);  // height err
        frame(4, -1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd2, ST_LOCKED);
        frame(0, -1, 1'b0, 1'b1, 1'b1, 1'b0, 8'd2, ST_LOCKED);   // empty frame
        frame(4, -1, 1'b1, 1'b1, 1'b0, 1'b1, 8'd3, ST_MEASURE);  // height 0 err
        frame(4, -1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd3, ST_LOCKED);   // solid 0x7FFF CRC

`ifdef DISP_SINK_CRC_EN
        check("crc_empty_const", a_err_cnt, 8'd3);
`endif

        // Mid-line reset, then two frame events before lock returns.
        for (int p = 0; p < 5; p++)
            cycle(1'b0, 1'b1, p, 4, BPC'(p), 5'd4, BPC'(p + 7));
        do_reset();
        frame(4, -1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, ST_MEASURE);
        frame(4, -1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, ST_LOCKED);
        repeat (4) cycle(1'b0, 1'b0, 0, 0, '0, '0, '0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
